// File: rtl/retro_vending_multi.sv
// retro_vending_multi -- multi-product coin vending controller.
//
// Takes nickel/dime/quarter pulses into a credit register, vends one of
// NUM_ITEMS products at per-item prices with per-item stock counters, then
// pays change back one coin per cycle, largest coin first.
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   coin_5/coin_10/coin_25      coin pulses, one coin per high cycle
//   select, item_sel            purchase request and product index
//   cancel                      refund request
//   dispense, item_out          one-cycle vend pulse and vended product index
//   change_5/change_10/change_25  one-cycle change-coin pulses (at most one high)
//   coin_reject                 previous cycle's coins were refused
//   deny                        previous cycle's select was refused
//   credit                      current credit (registered)
//   sold_out                    bit i set when product i has no stock
//   busy                        high while vending or paying change
module retro_vending_multi #(
  parameter int unsigned                   NUM_ITEMS  = 4,
  parameter int unsigned                   CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd75, 8'd50, 8'd35, 8'd25},
  parameter int unsigned                   MAX_CREDIT = 200,
  parameter int unsigned                   STOCK_W    = 4,
  parameter int unsigned                   STOCK_INIT = 3,
  localparam int unsigned                  IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_5,
  input  logic                 coin_10,
  input  logic                 coin_25,
  input  logic                 select,
  input  logic [IDX_W-1:0]     item_sel,
  input  logic                 cancel,
  output logic                 dispense,
  output logic [IDX_W-1:0]     item_out,
  output logic                 change_5,
  output logic                 change_10,
  output logic                 change_25,
  output logic                 coin_reject,
  output logic                 deny,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    MAX_C     = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] Q25       = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] D10       = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] N5        = CREDIT_W'(5);
  localparam logic [STOCK_W-1:0]  STOCK_RST = STOCK_W'(STOCK_INIT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    item_q, item_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                coin_reject_q, coin_reject_d;
  logic                deny_q, deny_d;

  logic [SUM_W-1:0]    coin_sum;
  logic [SUM_W-1:0]    credit_sum;
  logic                coins_in;
  logic                sel_ok;
  logic [CREDIT_W-1:0] vend_price;
  logic [CREDIT_W-1:0] chg_amt;

  always_comb begin
    coin_sum   = (coin_5  ? SUM_W'(5)  : '0)
               + (coin_10 ? SUM_W'(10) : '0)
               + (coin_25 ? SUM_W'(25) : '0);
    credit_sum = {1'b0, credit_q} + coin_sum;
    coins_in   = coin_5 | coin_10 | coin_25;
    sel_ok     = 1'b0;
    vend_price = '0;
    // Index decode by equality so an out-of-range item_sel simply never matches.
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == IDX_W'(i))
        sel_ok = (stock_q[i] != '0) && (credit_q >= PRICES[i*CREDIT_W +: CREDIT_W]);
      if (item_q == IDX_W'(i))
        vend_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    if (credit_q >= Q25)      chg_amt = Q25;
    else if (credit_q >= D10) chg_amt = D10;
    else if (credit_q >= N5)  chg_amt = N5;
    else                      chg_amt = '0;
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    stock_d       = stock_q;
    coin_reject_d = 1'b0;
    deny_d        = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coins_in;
          if (credit_q != '0) state_d = S_CHANGE;
        end else begin
          if (coins_in) begin
            if (credit_sum <= MAX_C) credit_d = credit_sum[CREDIT_W-1:0];
            else                     coin_reject_d = 1'b1;
          end
          if (select && sel_ok) begin
            item_d  = item_sel;
            state_d = S_VEND;
          end else begin
            deny_d  = select;
            state_d = (credit_d != '0) ? S_CREDIT : S_IDLE;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coins_in;
        credit_d      = credit_q - vend_price;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
          if (item_q == IDX_W'(i) && stock_q[i] != '0)
            stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
        state_d = (credit_d != '0) ? S_CHANGE : S_IDLE;
      end
      default: begin
        coin_reject_d = coins_in;
        credit_d      = credit_q - chg_amt;
        // A residue below 5 cannot occur; dropping it keeps CHANGE from stalling.
        if (credit_d == '0 || chg_amt == '0) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      item_q        <= '0;
      coin_reject_q <= 1'b0;
      deny_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_RST;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      coin_reject_q <= coin_reject_d;
      deny_q        <= deny_d;
      stock_q       <= stock_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign dispense    = (state_q == S_VEND);
  assign item_out    = dispense ? item_q : '0;
  assign change_25   = (state_q == S_CHANGE) && (chg_amt == Q25);
  assign change_10   = (state_q == S_CHANGE) && (chg_amt == D10);
  assign change_5    = (state_q == S_CHANGE) && (chg_amt == N5);
  assign coin_reject = coin_reject_q;
  assign deny        = deny_q;
  assign credit      = credit_q;
  assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_retro_vending_multi.sv
// Testbench for retro_vending_multi: the driver pushes the expected outputs
// for the cycle after each driven edge; the monitor pops and compares them.
module tb_retro_vending_multi;

  localparam logic [2:0] N   = 3'b000;
  localparam logic [2:0] C5  = 3'b001;
  localparam logic [2:0] C10 = 3'b010;
  localparam logic [2:0] C25 = 3'b100;
  localparam logic [2:0] ALL = 3'b111;

  typedef struct {
    string      tag;
    logic       disp;
    logic [1:0] item;
    logic [2:0] chg;   // {change_25, change_10, change_5}
    logic       rej;
    logic       dny;
    logic [7:0] cr;
    logic [3:0] sold;
    logic       bsy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_5 = 1'b0, coin_10 = 1'b0, coin_25 = 1'b0;
  logic       select = 1'b0, cancel = 1'b0;
  logic [1:0] item_sel = '0;
  logic       dispense, change_5, change_10, change_25, coin_reject, deny, busy;
  logic [1:0] item_out;
  logic [7:0] credit;
  logic [3:0] sold_out;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        exp_q[$];

  retro_vending_multi #(
    .NUM_ITEMS (4),
    .CREDIT_W  (8),
    .PRICES    ({8'd75, 8'd50, 8'd35, 8'd25}),
    .MAX_CREDIT(200),
    .STOCK_W   (4),
    .STOCK_INIT(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .coin_25    (coin_25),
    .select     (select),
    .item_sel   (item_sel),
    .cancel     (cancel),
    .dispense   (dispense),
    .item_out   (item_out),
    .change_5   (change_5),
    .change_10  (change_10),
    .change_25  (change_25),
    .coin_reject(coin_reject),
    .deny       (deny),
    .credit     (credit),
    .sold_out   (sold_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic disp, input logic [1:0] item, input logic [2:0] chg,
                              input logic rej, input logic dny, input logic [7:0] cr,
                              input logic [3:0] sold, input logic bsy);
    exp_t e;
    e.tag = ""; e.disp = disp; e.item = item; e.chg = chg; e.rej = rej;
    e.dny = dny; e.cr = cr; e.sold = sold; e.bsy = bsy;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic [2:0] coins, input logic sel,
                       input logic [1:0] isel, input logic can, input string tag, input exp_t e);
    @(negedge clk);
    reset = rst;
    {coin_25, coin_10, coin_5} = coins;
    select = sel; item_sel = isel; cancel = can;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val({e.tag, ".dispense"}, 32'(dispense), 32'(e.disp));
        check_val({e.tag, ".item_out"}, 32'(item_out), 32'(e.item));
        check_val({e.tag, ".change"}, 32'({change_25, change_10, change_5}), 32'(e.chg));
        check_val({e.tag, ".coin_reject"}, 32'(coin_reject), 32'(e.rej));
        check_val({e.tag, ".deny"}, 32'(deny), 32'(e.dny));
        check_val({e.tag, ".credit"}, 32'(credit), 32'(e.cr));
        check_val({e.tag, ".sold_out"}, 32'(sold_out), 32'(e.sold));
        check_val({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
      end
    end
  end

  initial begin : stimulus
    drive(1, N, 0, 0, 0, "rst_a", ex(0, 0, N, 0, 0, 0, 4'h0, 0));
    drive(1, N, 0, 0, 0, "rst_b", ex(0, 0, N, 0, 0, 0, 4'h0, 0));

    // 25+25+10, buy item 2 (50), one dime back
    drive(0, C25, 0, 0, 0, "t1_c25a", ex(0, 0, N, 0, 0, 25, 4'h0, 0));
    drive(0, C25, 0, 0, 0, "t1_c25b", ex(0, 0, N, 0, 0, 50, 4'h0, 0));
    drive(0, C10, 0, 0, 0, "t1_c10",  ex(0, 0, N, 0, 0, 60, 4'h0, 0));
    drive(0, N,   1, 2, 0, "t1_sel2", ex(1, 2, N, 0, 0, 60, 4'h0, 1));
    drive(0, N,   0, 0, 0, "t1_chg",  ex(0, 0, 3'b010, 0, 0, 10, 4'h0, 1));
    drive(0, N,   0, 0, 0, "t1_idle", ex(0, 0, N, 0, 0, 0, 4'h0, 0));
    drive(0, N,   0, 0, 1, "cancel0", ex(0, 0, N, 0, 0, 0, 4'h0, 0));

    // deny at 30 for item 1 (35); same-cycle coin still counts; exact-price vend
    drive(0, C25, 0, 0, 0, "t2_c25",    ex(0, 0, N, 0, 0, 25, 4'h0, 0));
    drive(0, C5,  0, 0, 0, "t2_c5",     ex(0, 0, N, 0, 0, 30, 4'h0, 0));
    drive(0, N,   1, 1, 0, "t2_deny",   ex(0, 0, N, 0, 1, 30, 4'h0, 0));
    drive(0, C5,  1, 1, 0, "t2_c5deny", ex(0, 0, N, 0, 1, 35, 4'h0, 0));
    drive(0, N,   1, 1, 0, "t2_sel1",   ex(1, 1, N, 0, 0, 35, 4'h0, 1));
    drive(0, N,   0, 0, 0, "t2_idle",   ex(0, 0, N, 0, 0, 0, 4'h0, 0));

    // credit 100, cancel -> four quarters; coins refused during change
    for (int k = 1; k <= 4; k++)
      drive(0, C25, 0, 0, 0, "t3_c25", ex(0, 0, N, 0, 0, 8'(25 * k), 4'h0, 0));
    drive(0, C5,  0, 0, 1, "t3_cancel", ex(0, 0, 3'b100, 1, 0, 100, 4'h0, 1));
    drive(0, C10, 0, 0, 0, "t3_c10rej", ex(0, 0, 3'b100, 1, 0, 75, 4'h0, 1));
    drive(0, N,   1, 0, 0, "t3_selign", ex(0, 0, 3'b100, 0, 0, 50, 4'h0, 1));
    drive(0, N,   0, 0, 0, "t3_q4",     ex(0, 0, 3'b100, 0, 0, 25, 4'h0, 1));
    drive(0, N,   0, 0, 0, "t3_done",   ex(0, 0, N, 0, 0, 0, 4'h0, 0));

    // drain item 0 stock, then a refused fourth purchase
    for (int v = 0; v < 3; v++) begin
      drive(0, C25, 0, 0, 0, "t4_c25",  ex(0, 0, N, 0, 0, 25, 4'h0, 0));
      drive(0, N,   1, 0, 0, "t4_sel0", ex(1, 0, N, 0, 0, 25, 4'h0, 1));
      drive(0, N,   0, 0, 0, "t4_idle", ex(0, 0, N, 0, 0, 0, (v == 2) ? 4'h1 : 4'h0, 0));
    end
    drive(0, C25, 0, 0, 0, "t4_c25x",  ex(0, 0, N, 0, 0, 25, 4'h1, 0));
    drive(0, N,   1, 0, 0, "t4_soldo", ex(0, 0, N, 0, 1, 25, 4'h1, 0));
    drive(0, N,   0, 0, 1, "t4_cancl", ex(0, 0, 3'b100, 0, 0, 25, 4'h1, 1));
    drive(0, N,   0, 0, 0, "t4_done",  ex(0, 0, N, 0, 0, 0, 4'h1, 0));

    // credit ceiling: 190 + 30 refused, 190 + 10 reaches 200, 200 + 5 refused
    for (int k = 1; k <= 4; k++)
      drive(0, ALL, 0, 0, 0, "t5_all", ex(0, 0, N, 0, 0, 8'(40 * k), 4'h1, 0));
    drive(0, C25,    0, 0, 0, "t5_c25",   ex(0, 0, N, 0, 0, 185, 4'h1, 0));
    drive(0, C5,     0, 0, 0, "t5_c5",    ex(0, 0, N, 0, 0, 190, 4'h1, 0));
    drive(0, 3'b101, 0, 0, 0, "t5_over",  ex(0, 0, N, 1, 0, 190, 4'h1, 0));
    drive(0, C10,    0, 0, 0, "t5_max",   ex(0, 0, N, 0, 0, 200, 4'h1, 0));
    drive(0, C5,     0, 0, 0, "t5_over2", ex(0, 0, N, 1, 0, 200, 4'h1, 0));
    drive(0, N,      0, 0, 1, "t5_cancl", ex(0, 0, 3'b100, 0, 0, 200, 4'h1, 1));
    for (int k = 1; k <= 8; k++)
      drive(0, N, 0, 0, 0, "t5_pay", ex(0, 0, (k < 8) ? 3'b100 : N, 0, 0, 8'(200 - 25 * k),
                                        4'h1, k < 8));

    // credit 90, buy item 3 (75), reset during the dime cycle
    drive(0, ALL, 0, 0, 0, "t6_a",    ex(0, 0, N, 0, 0, 40, 4'h1, 0));
    drive(0, ALL, 0, 0, 0, "t6_b",    ex(0, 0, N, 0, 0, 80, 4'h1, 0));
    drive(0, C10, 0, 0, 0, "t6_c",    ex(0, 0, N, 0, 0, 90, 4'h1, 0));
    drive(0, N,   1, 3, 0, "t6_sel3", ex(1, 3, N, 0, 0, 90, 4'h1, 1));
    drive(0, C5,  0, 0, 0, "t6_vrej", ex(0, 0, 3'b010, 1, 0, 15, 4'h1, 1));
    drive(1, N,   0, 0, 0, "t6_rst",  ex(0, 0, N, 0, 0, 0, 4'h0, 0));
    drive(0, N,   0, 0, 0, "t6_post", ex(0, 0, N, 0, 0, 0, 4'h0, 0));
    drive(0, N,   0, 0, 0, "t6_post2", ex(0, 0, N, 0, 0, 0, 4'h0, 0));

    @(negedge clk);
    @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retro_vending_multi.md
# retro_vending_multi

Parametrised multi-product vending controller; next generation of the single-product retro vending FSM. Accepts nickel/dime/quarter pulses into a credit register, vends one of `NUM_ITEMS` products at per-item prices with per-item stock tracking, then returns change one coin per cycle, greedy largest-first. Sits between the coin-acceptor/keypad front end and the dispenser/coin-hopper drivers.

## Interface
- `NUM_ITEMS`, 4: number of products; `IDX_W = $clog2(NUM_ITEMS)` (min 1), derived.
- `CREDIT_W`, 8: width of credit and price fields.
- `PRICES`, {8'd75, 8'd50, 8'd35, 8'd25}: packed `NUM_ITEMS*CREDIT_W` price list; item 0 in LSBs; every price a nonzero multiple of 5.
- `MAX_CREDIT`, 200: credit ceiling, multiple of 5; requires `MAX_CREDIT + 25 < 2**CREDIT_W`.
- `STOCK_W`, 4: per-item stock counter width.
- `STOCK_INIT`, 3: stock loaded into every item at reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `coin_5`, `coin_10`, `coin_25`  in  1 each  coin pulses; each cycle high = one coin.
- `select`  in  1  purchase request, sampled per cycle.
- `item_sel`  in  IDX_W  product index, valid with `select`.
- `cancel`  in  1  refund request.
- `dispense`  out  1  one-cycle vend pulse.
- `item_out`  out  IDX_W  index of dispensed item, valid with `dispense`; 0 otherwise.
- `change_5`, `change_10`, `change_25`  out  1 each  one-cycle change-coin pulses; at most one high per cycle.
- `coin_reject`  out  1  one-cycle pulse: coins in previous cycle refused.
- `deny`  out  1  one-cycle pulse: previous cycle's select refused.
- `credit`  out  CREDIT_W  current credit, registered.
- `sold_out`  out  NUM_ITEMS  bit i high when stock[i] == 0.
- `busy`  out  1  high in VEND and CHANGE.

## Operation
- States: IDLE (credit 0), CREDIT (credit > 0), VEND, CHANGE.
- Coin accept (IDLE/CREDIT): `sum` = 5·coin_5 + 10·coin_10 + 25·coin_25 over all asserted inputs; if credit + sum <= MAX_CREDIT, credit += sum, else whole cycle's coins refused, credit unchanged, `coin_reject` pulses. IDLE -> CREDIT when resulting credit > 0.
- Coins in VEND/CHANGE: always refused with `coin_reject`.
- Select (IDLE/CREDIT): valid iff item_sel < NUM_ITEMS, stock[item_sel] > 0, credit (value before same-cycle coins) >= price[item_sel]. Valid -> VEND, item latched; same-cycle coins still accepted per coin rule. Invalid -> `deny`, state unchanged.
- VEND (exactly one cycle): `dispense`=1, `item_out`=latched item, credit -= price, stock[item] -= 1. Next: CHANGE if remaining credit > 0, else IDLE.
- Cancel (IDLE/CREDIT): beats simultaneous select (no deny raised); same-cycle coins refused. credit > 0 -> CHANGE; credit 0 -> no effect. Ignored in VEND/CHANGE.
- CHANGE: each cycle emit the largest coin <= credit (25, then 10, then 5), subtract it; when credit reaches 0 -> IDLE. select ignored (no deny).
- Arithmetic unsigned CREDIT_W; credit never negative, never exceeds MAX_CREDIT; stock saturates at 0 (a vend is never issued on 0 stock).

## Timing
- Reset: state IDLE, credit 0, all stock = STOCK_INIT, `sold_out` 0 (or all ones if STOCK_INIT = 0), all pulse outputs 0, `item_out` 0, `busy` 0. Reset mid-VEND/CHANGE aborts; undelivered change discarded.
- Coin at edge k -> `credit` updated after edge k; `coin_reject` high cycle k+1.
- Select at edge k -> `dispense` high cycle k+1; first change pulse cycle k+2; N change coins occupy cycles k+2..k+N+1; IDLE after edge k+N+1.
- Cancel at edge k -> first change pulse cycle k+1.
- `deny` high cycle k+1 after refused select at edge k.
- `sold_out` and `credit` update the cycle after the VEND cycle's edge.

## Test plan
- Reset, insert 25,25,10 (separate cycles), select item 2 (50) -> dispense one cycle, item_out=2, then one change_10 pulse, credit 0, IDLE.
- Credit 30, select item 1 (35) -> deny pulse, credit stays 30; add coin_5, select item 1 -> dispense, no change pulses.
- Credit 100, cancel -> change_25 x4 on consecutive cycles, credit 0; coin_10 during CHANGE -> coin_reject, credit unaffected.
- Vend item 0 three times (STOCK_INIT=3) -> sold_out[0]=1; fourth select item 0 with credit 25 -> deny, no dispense.
- Credit 190, coin_25 and coin_5 same cycle -> coin_reject, credit 190; then coin_10 -> credit 200.
- Credit 90, select item 3 (75) -> dispense, change 10 then 5; assert reset during change_10 cycle -> next cycle credit 0, no further change pulses.
